// File: rtl/regbank_write_arbiter.sv
// rtl/regbank_write_arbiter.sv - round-robin arbiter for the register bank write port
// Three producers share Sel_C/Data_C; a 32-entry scoreboard tracks outstanding writes.
module regbank_write_arbiter #(
    parameter logic [5:0] IDLE_SEL = 6'd34,
    parameter int         NREQ     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [6*NREQ-1:0]    req_sel,
    input  logic [16*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [5:0]           wr_sel,
    output logic [15:0]          wr_data,
    input  logic                 claim_valid,
    input  logic [4:0]           claim_sel,
    input  logic [4:0]           rd_sel_a,
    input  logic [5:0]           rd_sel_b,
    output logic                 busy_a,
    output logic                 busy_b,
    output logic                 hazard,
    output logic [31:0]          busy_vec
);

    logic [1:0]      r_last_grant;
    logic [5:0]      r_wr_sel;
    logic [15:0]     r_wr_data;
    logic [31:0]     r_busy;

    logic [NREQ-1:0] w_grant;
    logic [1:0]      w_gidx;
    logic [1:0]      w_idx;
    logic            w_found;
    logic [5:0]      w_sel;
    logic [15:0]     w_data;
    logic [31:0]     w_busy_next;

    // Search starts one past the last winner and wraps, so every waiting producer
    // is served within NREQ cycles.
    always_comb begin
        w_grant = '0;
        w_gidx  = 2'd0;
        w_idx   = 2'd0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = 2'((32'(r_last_grant) + 32'd1 + 32'(k)) % 32'(NREQ));
            if (!w_found && req_valid[w_idx]) begin
                w_found         = 1'b1;
                w_gidx          = w_idx;
                w_grant[w_idx]  = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel  = '0;
        w_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant[k]) begin
                w_sel  = req_sel[6*k +: 6];
                w_data = req_data[16*k +: 16];
            end
        end
    end

    // Commit clears first so a same-cycle claim of that register wins.
    always_comb begin
        w_busy_next = r_busy;
        if (!r_wr_sel[5]) begin
            w_busy_next[r_wr_sel[4:0]] = 1'b0;
        end
        if (claim_valid) begin
            w_busy_next[claim_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 2'd2;
            r_wr_sel     <= IDLE_SEL;
            r_wr_data    <= '0;
            r_busy       <= '0;
        end else begin
            r_busy <= w_busy_next;
            if (w_found) begin
                r_last_grant <= w_gidx;
                r_wr_sel     <= w_sel;
                r_wr_data    <= w_data;
            end else begin
                r_wr_sel     <= IDLE_SEL;
                r_wr_data    <= '0;
            end
        end
    end

    assign req_ready = w_grant;
    assign wr_sel    = r_wr_sel;
    assign wr_data   = r_wr_data;
    assign busy_vec  = r_busy;
    assign busy_a    = r_busy[rd_sel_a];
    assign busy_b    = rd_sel_b[5] ? 1'b0 : r_busy[rd_sel_b[4:0]];
    assign hazard    = busy_a | busy_b;

endmodule

// File: doc/regbank_write_arbiter.md
# regbank_write_arbiter

Shares the register bank's single write port (Sel_C/Data_C) between three producers: ALU writeback, memory load return and I/O input. Round-robin arbitration with valid/ready handshakes; grants are registered into the write port. A 32-entry pending-write scoreboard marks destination registers with an outstanding write so the issue stage can stall on read-after-write hazards. Sits between the execute/memory/I-O units and the register bank; the issue stage talks to it through the claim and query ports.

## Interface
- IDLE_SEL, default 34: write select driven when no write is granted. The bank writes every clock, so idle cycles target scratch register r34.
- NREQ, default 3: number of requesters. Fixed at 3 in this revision.
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  3  per-requester write request (bit 0 = ALU, 1 = MEM, 2 = IO).
- req_sel  input  3x6 (18, packed, requester i at [6i+5:6i])  destination select.
- req_data  input  3x16 (48, packed)  write data.
- req_ready  output  3  grant; transfer occurs when req_valid[i] & req_ready[i] at the clock edge.
- wr_sel  output  6  to bank Sel_C, registered.
- wr_data  output  16  to bank Data_C, registered.
- claim_valid  input  1  issue stage reserves a destination.
- claim_sel  input  5  register being reserved (r0-r31).
- rd_sel_a  input  5  query select, operand A.
- rd_sel_b  input  6  query select, operand B.
- busy_a, busy_b  output  1 each  scoreboard bit for the queried register. Combinational.
- hazard  output  1  busy_a | busy_b. Combinational.
- busy_vec  output  32  full scoreboard, for debug.

## Operation
- Arbitration: combinational, one-hot grant among asserted req_valid bits.
  - Priority starts at the requester after last_grant and wraps modulo 3.
  - req_ready[i] = grant[i]; at most one bit high per cycle. All zero when no valid.
- last_grant: 2-bit register, updated only on a completed transfer. Reset value 2, so requester 0 has first priority.
- Write-port register:
  - On transfer: wr_sel <= granted req_sel, wr_data <= granted req_data.
  - Otherwise: wr_sel <= IDLE_SEL, wr_data <= 0.
- Requester contract: once req_valid is raised it holds req_valid/sel/data stable until ready. The arbiter does not check this.
- Scoreboard: 32 busy bits.
  - claim_valid sets busy[claim_sel].
  - Each committed write (registered wr_sel < 32, i.e. not idle) clears busy[wr_sel[4:0]] at the edge the bank captures it.
  - Same register set and cleared in one cycle: set wins (newer outstanding write).
  - wr_sel values 32-63 never touch the scoreboard.
  - rd_sel_b >= 32: busy_b = 0.
- Claiming an already-busy register is legal; the bit stays set and is cleared by the first commit to that register.
- reset: busy_vec = 0, last_grant = 2, wr_sel = IDLE_SEL, wr_data = 0. An in-flight transfer on the reset edge is dropped; requesters must re-present.

## Timing
- Reset values:
  - wr_sel = 34, wr_data = 0, busy_vec = 0.
  - req_ready = 0 unless req_valid is high; busy_a, busy_b and hazard = 0 after the reset edge.
- Handshake at edge k:
  - wr_sel/wr_data are valid during cycle k..k+1.
  - The bank writes at edge k+1, and busy clears at edge k+1.
  - The bank's registered read returns the new value after edge k+2.
- Claim at edge k: busy and hazard visible combinationally from cycle k..k+1.
- Throughput: one write per cycle. Each continuously requesting producer is granted at least once every 3 cycles.
- No combinational path from req_* to wr_*; only req_valid -> req_ready and rd_sel -> busy are combinational.

## Test plan
- Reset check: hold reset 2 cycles with all req_valid = 1. Required: wr_sel = 34, wr_data = 0, busy_vec = 0 after the edge. The first grant after reset goes to req 0.
- Single write: ALU requests sel 5, data 0xBEEF at edge k. Required:
  - req_ready[0] = 1 in that cycle.
  - wr_sel = 5 and wr_data = 0xBEEF for exactly one cycle, then back to 34/0.
- Round-robin fairness: all three valid for 6 cycles, sels 1/2/3. Required: grant order 0,1,2,0,1,2, and wr_sel sequence 1,2,3,1,2,3 lagging one cycle.
- Scoreboard lifecycle: claim r7 at edge k, then rd_sel_a = 7. Required:
  - busy_a = hazard = 1 from cycle k.
  - MEM write to sel 7 handshakes at edge m; busy_a drops after edge m+1.
- Simultaneous set/clear: commit of r9 and claim_sel = 9 on the same edge. Required: busy[9] remains 1. Also, rd_sel_b = 34 always gives busy_b = 0.
- Reset mid-operation: handshake and reset on the same edge. Required: wr_sel = 34 next cycle, no write issued, busy_vec = 0.
